ps2_keyboard_rx: RTL and testbench
==================================

PS2_KEYBOARD_RX -- requirements
Module: ps2_keyboard_rx

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, scancode FIFO entries; power of 2, at least 2.
REQ-002 Parameter SYNC_STAGES, default 3, synchroniser flops on ps2_clk and ps2_data; at least 2.
REQ-003 Parameter TIMEOUT_CYCLES, default 50000, clk cycles without a ps2_clk falling edge before a partial frame is abandoned.
REQ-004 clk  in  1  single system clock; all logic on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 ps2_clk  in  1  asynchronous PS/2 clock from the device.
REQ-007 ps2_data  in  1  asynchronous PS/2 data from the device.
REQ-008 key_valid  out  1  FIFO head entry is valid.
REQ-009 key_ready  in  1  consumer accepts the head entry when key_valid is also 1.
REQ-010 key_code  out  8  head scancode, with E0/F0 prefixes stripped.
REQ-011 key_ext  out  1  head scancode was preceded by E0.
REQ-012 key_break  out  1  head scancode was preceded by F0 (key release).
REQ-013 fifo_count  out  $clog2(FIFO_DEPTH)+1  number of stored entries.
REQ-014 frame_err  out  1  one-cycle pulse for a bad start bit, parity, stop bit or timeout.
REQ-015 overflow  out  1  one-cycle pulse when a decoded key is dropped because the FIFO is full.

Function
REQ-016 ps2_clk and ps2_data SHALL each pass through SYNC_STAGES flops; a falling edge is synchronised-previous=1 and synchronised-current=0.
REQ-017 Bits SHALL be sampled from synchronised ps2_data only in falling-edge cycles.
REQ-018 Frame format: start=0, 8 data bits LSB first, odd parity over data plus parity, stop=1.
REQ-019 The frame FSM SHALL use the states IDLE, DATA, PARITY and STOP, with these transitions:
- IDLE to DATA on an edge with data 0.
- IDLE stays in IDLE on an edge with data 1; frame_err is not pulsed.
- DATA to PARITY after the 8th data edge.
- PARITY to STOP on the next edge.
- STOP to IDLE on the next edge.
REQ-020 A frame is good only if parity is odd and stop=1; otherwise frame_err SHALL pulse and the byte SHALL be discarded.
REQ-021 In any state except IDLE, TIMEOUT_CYCLES consecutive cycles without an edge SHALL force IDLE, pulse frame_err and clear the prefix flags; the watchdog counter restarts on every edge.
REQ-022 Prefix decoding of a good byte:
- E0 sets the ext flag.
- F0 sets the brk flag.
- Any other byte pushes {ext, brk, byte} into the FIFO and clears both flags.
- A frame_err also clears both flags.
REQ-023 Latency: key_valid SHALL rise exactly 2 clk cycles after the cycle in which the stop-bit edge is detected, when the FIFO was empty.
REQ-024 Handshake: the head entry is popped in a cycle with key_valid&&key_ready. key_code, key_ext and key_break SHALL hold stable while key_valid=1 and key_ready=0.
REQ-025 Push with the FIFO full and no pop in the same cycle: the entry is dropped, overflow pulses, and the contents are unchanged.
REQ-026 Push and pop in the same cycle with the FIFO full: both succeed, no overflow, fifo_count unchanged.
REQ-027 Push and pop in the same cycle with the FIFO empty: the entry is written, and key_valid rises in the next cycle.
REQ-028 FIFO pointers SHALL wrap modulo FIFO_DEPTH; fifo_count ranges from 0 to FIFO_DEPTH.
REQ-029 A pop with key_valid=0 SHALL be ignored.

Reset
REQ-030 When reset=1, the following SHALL all return to their idle values on the next clk edge:
- FSM to IDLE.
- Bit counter, watchdog counter and prefix flags to 0.
- FIFO pointers to 0.
- Synchroniser flops to 1.
REQ-031 Reset output values: key_valid=0, fifo_count=0, frame_err=0, overflow=0, key_code=0, key_ext=0, key_break=0.
REQ-032 Reset mid-frame SHALL discard the partial frame; decoding resumes on the next start bit after reset is released.

Structure
REQ-033 Package ps2_pkg SHALL hold:
- The frame-bit constants.
- The prefix constants PS2_EXT=8'hE0 and PS2_BRK=8'hF0.
- The FSM state enum.
- The 10-bit FIFO entry typedef {ext, brk, code}.
REQ-034 Storage SHALL be one sub-module, ps2_fifo, a parametrised synchronous FIFO with push/pop/full/empty/count.
REQ-035 The frame receiver and prefix decoder SHALL stay in ps2_keyboard_rx.

Verification
REQ-036 Send frame 1C (parity 0) with key_ready=1: key_valid pulses once, key_code=1C, key_ext=0, key_break=0.
REQ-037 Send F0,1C: one entry with code 1C, break=1. Send E0,F0,75: one entry with code 75, ext=1, break=1.
REQ-038 Send 1C with wrong parity: frame_err pulses once, no entry. The following frame 32 decodes correctly.
REQ-039 With key_ready=0, send FIFO_DEPTH+1 keys: fifo_count=FIFO_DEPTH and overflow pulses once. Then drain: entries come out in order and the last key is absent.
REQ-040 Stop ps2_clk after 4 data bits for TIMEOUT_CYCLES: frame_err pulses and the FSM is in IDLE. The next full frame 1C decodes correctly.
REQ-041 Assert reset for 1 cycle mid-frame with 3 entries queued: fifo_count=0 and key_valid=0 on the next cycle. The next frame decodes correctly.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 receiver definitions: frame-bit constants, scancode prefixes,
// frame FSM states and the queued scancode entry layout.
package ps2_pkg;

  localparam int         PS2_DATA_BITS = 8;
  localparam logic       PS2_START_BIT = 1'b0;
  localparam logic       PS2_STOP_BIT  = 1'b1;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } ps2_state_e;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_entry_t;

  // Odd parity holds when data plus parity bit carry an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_fifo.sv
// Parametrised synchronous FIFO; the head word is read asynchronously so it is
// presented in the same cycle the FIFO becomes non-empty.
module ps2_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 10
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_pop  = i_pop && !o_empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: synchronises the device lines, deframes 11-bit
// frames, folds E0/F0 prefixes into flags and queues decoded scancodes.
module ps2_keyboard_rx
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int SYNC_STAGES    = 3,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          ps2_clk,
  input  logic                          ps2_data,
  output logic                          key_valid,
  input  logic                          key_ready,
  output logic [7:0]                    key_code,
  output logic                          key_ext,
  output logic                          key_break,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          frame_err,
  output logic                          overflow
);

  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);

  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [SYNC_STAGES-1:0] r_data_sync;
  logic                   r_clk_prev;
  logic                   w_fall;
  logic                   w_bit;

  ps2_state_e             r_state;
  ps2_state_e             w_state_next;
  logic [2:0]             r_bit_cnt;
  logic [7:0]             r_shift;
  logic                   r_parity;
  logic [WDW-1:0]         r_wdog;
  logic                   w_timeout;
  logic                   w_stop_good;
  logic                   w_stop_bad;

  logic                   r_byte_vld;
  logic [7:0]             r_byte;
  logic                   r_ext;
  logic                   r_brk;
  logic                   r_frame_err;
  logic                   r_overflow;

  logic                   w_push;
  logic                   w_pop;
  ps2_entry_t             w_entry;
  logic [$bits(ps2_entry_t)-1:0] w_head_bits;
  ps2_entry_t             w_head;
  logic                   w_full;
  logic                   w_empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_clk_sync  <= '1;
      r_data_sync <= '1;
      r_clk_prev  <= 1'b1;
    end else begin
      r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], ps2_clk};
      r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], ps2_data};
      r_clk_prev  <= r_clk_sync[SYNC_STAGES-1];
    end
  end

  assign w_fall = r_clk_prev && !r_clk_sync[SYNC_STAGES-1];
  assign w_bit  = r_data_sync[SYNC_STAGES-1];

  assign w_timeout = (r_state != ST_IDLE) && !w_fall &&
                     (r_wdog == WDW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_stop_good  = 1'b0;
    w_stop_bad   = 1'b0;
    if (w_timeout) begin
      w_state_next = ST_IDLE;
    end else if (w_fall) begin
      case (r_state)
        ST_IDLE: begin
          if (w_bit == PS2_START_BIT) begin
            w_state_next = ST_DATA;
          end
        end
        ST_DATA: begin
          if (r_bit_cnt == 3'(PS2_DATA_BITS - 1)) begin
            w_state_next = ST_PARITY;
          end
        end
        ST_PARITY: w_state_next = ST_STOP;
        ST_STOP: begin
          w_state_next = ST_IDLE;
          if (odd_parity_ok(r_shift, r_parity) && (w_bit == PS2_STOP_BIT)) begin
            w_stop_good = 1'b1;
          end else begin
            w_stop_bad = 1'b1;
          end
        end
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  // The 3-bit counter wraps back to 0 on the 8th data edge, ready for the next frame.
  always_ff @(posedge clk) begin
    if (reset || w_timeout) begin
      r_bit_cnt <= '0;
      r_wdog    <= '0;
    end else begin
      if (w_fall && (r_state == ST_DATA)) begin
        r_bit_cnt <= r_bit_cnt + 3'd1;
      end
      if ((r_state == ST_IDLE) || w_fall) begin
        r_wdog <= '0;
      end else begin
        r_wdog <= r_wdog + WDW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_shift  <= '0;
      r_parity <= 1'b0;
    end else if (w_fall) begin
      if (r_state == ST_DATA) begin
        r_shift <= {w_bit, r_shift[7:1]};
      end
      if (r_state == ST_PARITY) begin
        r_parity <= w_bit;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_byte_vld  <= 1'b0;
      r_byte      <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_byte_vld  <= w_stop_good;
      r_frame_err <= w_stop_bad || w_timeout;
      if (w_stop_good) begin
        r_byte <= r_shift;
      end
    end
  end

  // Prefix flags accumulate across E0/F0 bytes and are consumed by the next scancode.
  always_ff @(posedge clk) begin
    if (reset || w_stop_bad || w_timeout) begin
      r_ext <= 1'b0;
      r_brk <= 1'b0;
    end else if (r_byte_vld) begin
      if (r_byte == PS2_EXT) begin
        r_ext <= 1'b1;
      end else if (r_byte == PS2_BRK) begin
        r_brk <= 1'b1;
      end else begin
        r_ext <= 1'b0;
        r_brk <= 1'b0;
      end
    end
  end

  assign w_push  = r_byte_vld && (r_byte != PS2_EXT) && (r_byte != PS2_BRK);
  assign w_entry = '{ext: r_ext, brk: r_brk, code: r_byte};
  assign w_pop   = key_valid && key_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= w_push && w_full && !w_pop;
    end
  end

  ps2_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(ps2_entry_t))
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (w_entry),
    .i_pop   (w_pop),
    .o_data  (w_head_bits),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (fifo_count)
  );

  assign w_head    = ps2_entry_t'(w_head_bits);
  assign key_valid = !w_empty;
  // Head fields read as zero while nothing is queued.
  assign key_code  = key_valid ? w_head.code : 8'h00;
  assign key_ext   = key_valid && w_head.ext;
  assign key_break = key_valid && w_head.brk;
  assign frame_err = r_frame_err;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Randomised PS/2 frame stimulus against a queue-based scancode model.
`timescale 1ns/1ps
module tb_ps2_keyboard_rx;

  localparam int DEPTH = 8;
  localparam int SYNC  = 3;
  localparam int TMO   = 300;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       key_ready = 1'b0;
  logic       key_valid;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_break;
  logic [3:0] fifo_count;
  logic       frame_err;
  logic       overflow;

  ps2_keyboard_rx #(
    .FIFO_DEPTH     (DEPTH),
    .SYNC_STAGES    (SYNC),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .key_code   (key_code),
    .key_ext    (key_ext),
    .key_break  (key_break),
    .fifo_count (fifo_count),
    .frame_err  (frame_err),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_checks = 0;
  int n_fail = 0;

  logic [9:0] exp_q[$];
  bit   m_ext = 0;
  bit   m_brk = 0;
  int   exp_err = 0;
  int   exp_ovf = 0;
  int   seen_err = 0;
  int   seen_ovf = 0;
  int   n_pops = 0;
  logic [9:0] last_pop = '0;
  int   t_stop = 0;
  int   t_rise = -1;

  bit rand_ready = 0;
  bit ready_fixed = 0;

  always @(posedge clk) begin
    #1;
    key_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_fixed;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference model: one call per complete frame, at the byte level.
  task automatic model_frame(input logic [7:0] data, input bit good);
    if (!good) begin
      exp_err++;
      m_ext = 0;
      m_brk = 0;
    end else if (data == 8'hE0) begin
      m_ext = 1;
    end else if (data == 8'hF0) begin
      m_brk = 1;
    end else begin
      if (exp_q.size() >= DEPTH) exp_ovf++;
      else exp_q.push_back({m_ext, m_brk, data});
      m_ext = 0;
      m_brk = 0;
    end
  endtask

  task automatic model_abort();
    exp_err++;
    m_ext = 0;
    m_brk = 0;
  endtask

  task automatic send_raw(input logic [10:0] bits, input int nbits);
    int hp;
    hp = $urandom_range(4, 8);
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      repeat (hp) @(posedge clk);
      #1;
      ps2_clk = 1'b0;
      if (i == 10) t_stop = cyc;
      repeat (hp) @(posedge clk);
      #1;
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] data, input bit bad_par, input bit bad_stop);
    logic par;
    par = (~^data) ^ bad_par;
    model_frame(data, !(bad_par || bad_stop));
    send_raw({~bad_stop, par, data, 1'b0}, 11);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 3000 && (exp_q.size() != 0 || key_valid); i++) @(posedge clk);
    repeat (10) @(posedge clk);
    #1;
    check(name, 32'(exp_q.size()), 32'd0);
    check({name, "_count"}, 32'(fifo_count), 32'd0);
  endtask

  function automatic logic [7:0] rand_code();
    logic [7:0] c;
    c = 8'($urandom_range(0, 255));
    while (c == 8'hE0 || c == 8'hF0) c = 8'($urandom_range(0, 255));
    return c;
  endfunction

  // Compare process: scoreboard pops, hold stability, pulse counting.
  logic       pv = 1'b0;
  logic       pr = 1'b0;
  logic [9:0] pd = '0;
  always @(negedge clk) begin
    logic [9:0] cur;
    cur = {key_ext, key_break, key_code};
    if (reset) begin
      pv = 1'b0;
      pr = 1'b0;
    end else begin
      if (frame_err) seen_err++;
      if (overflow) seen_ovf++;
      if (key_valid && !pv) t_rise = cyc;
      if (pv && !pr) begin
        check("hold_valid", 32'(key_valid), 32'd1);
        check("hold_entry", 32'(cur), 32'(pd));
      end
      if (key_valid && key_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL pop_unexpected: got %03h required no entry", cur);
        end else begin
          check("pop_entry", 32'(cur), 32'(exp_q.pop_front()));
        end
        last_pop = cur;
        n_pops++;
      end
      pv = key_valid;
      pr = key_ready;
      pd = cur;
    end
  end

  initial begin
    int p0;
    int e0;
    int o0;
    int r;

    repeat (4) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 32'(key_valid), 32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_err", 32'(frame_err), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_fields", 32'({key_ext, key_break, key_code}), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    // Single key, latency from stop edge
    ready_fixed = 1;
    p0 = n_pops;
    t_rise = -1;
    send_byte(8'h1C, 0, 0);
    repeat (20) @(posedge clk);
    #1;
    check("latency", 32'(t_rise - t_stop), 32'(SYNC + 2));
    check("single_pops", 32'(n_pops - p0), 32'd1);
    check("single_code", 32'(last_pop), 32'h01C);

    // Prefixed keys
    p0 = n_pops;
    send_byte(8'hF0, 0, 0);
    send_byte(8'h1C, 0, 0);
    repeat (20) @(posedge clk);
    #1;
    check("brk_pops", 32'(n_pops - p0), 32'd1);
    check("brk_code", 32'(last_pop), 32'h11C);
    p0 = n_pops;
    send_byte(8'hE0, 0, 0);
    send_byte(8'hF0, 0, 0);
    send_byte(8'h75, 0, 0);
    repeat (20) @(posedge clk);
    #1;
    check("ext_brk_pops", 32'(n_pops - p0), 32'd1);
    check("ext_brk_code", 32'(last_pop), 32'h375);

    // Parity and stop-bit errors
    p0 = n_pops;
    e0 = seen_err;
    send_byte(8'h1C, 1, 0);
    repeat (20) @(posedge clk);
    #1;
    check("par_err_once", 32'(seen_err - e0), 32'd1);
    check("par_err_nopop", 32'(n_pops - p0), 32'd0);
    send_byte(8'h32, 0, 0);
    repeat (20) @(posedge clk);
    #1;
    check("after_err_code", 32'(last_pop), 32'h032);
    e0 = seen_err;
    send_byte(8'h4B, 0, 1);
    repeat (20) @(posedge clk);
    #1;
    check("stop_err_once", 32'(seen_err - e0), 32'd1);
    wait_drain("drain_a");

    // Overflow with consumer stalled
    ready_fixed = 0;
    repeat (3) @(posedge clk);
    #1;
    o0 = seen_ovf;
    for (int i = 0; i < DEPTH + 1; i++) send_byte(rand_code(), 0, 0);
    repeat (20) @(posedge clk);
    #1;
    check("full_count", 32'(fifo_count), 32'(DEPTH));
    check("ovf_once", 32'(seen_ovf - o0), 32'd1);
    check("full_valid", 32'(key_valid), 32'd1);
    p0 = n_pops;
    ready_fixed = 1;
    wait_drain("drain_ovf");
    check("drain_pops", 32'(n_pops - p0), 32'(DEPTH));

    // Watchdog abandons a partial frame and clears pending prefix
    e0 = seen_err;
    send_byte(8'hF0, 0, 0);
    model_abort();
    send_raw(11'b000_1010_1010, 5);
    repeat (TMO + 40) @(posedge clk);
    #1;
    check("timeout_err", 32'(seen_err - e0), 32'd1);
    send_byte(8'h1C, 0, 0);
    repeat (20) @(posedge clk);
    #1;
    check("after_timeout_code", 32'(last_pop), 32'h01C);

    // Randomised traffic with a random consumer
    rand_ready = 1;
    for (int i = 0; i < 30; i++) begin
      r = $urandom_range(0, 99);
      if (r < 8)       send_byte(rand_code(), 1, 0);
      else if (r < 12) send_byte(rand_code(), 0, 1);
      else if (r < 30) send_byte(8'hE0, 0, 0);
      else if (r < 50) send_byte(8'hF0, 0, 0);
      else             send_byte(rand_code(), 0, 0);
    end
    rand_ready = 0;
    ready_fixed = 1;
    wait_drain("drain_rand");

    // Reset mid-frame with entries queued
    ready_fixed = 0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) send_byte(rand_code(), 0, 0);
    repeat (20) @(posedge clk);
    #1;
    check("pre_rst_count", 32'(fifo_count), 32'd3);
    send_raw(11'b000_0000_0110, 4);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("post_rst_count", 32'(fifo_count), 32'd0);
    check("post_rst_valid", 32'(key_valid), 32'd0);
    exp_q.delete();
    m_ext = 0;
    m_brk = 0;
    ready_fixed = 1;
    repeat (5) @(posedge clk);
    #1;
    p0 = n_pops;
    send_byte(8'h32, 0, 0);
    repeat (20) @(posedge clk);
    #1;
    check("post_rst_pops", 32'(n_pops - p0), 32'd1);
    check("post_rst_code", 32'(last_pop), 32'h032);

    check("total_err", 32'(seen_err), 32'(exp_err));
    check("total_ovf", 32'(seen_ovf), 32'(exp_ovf));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "time limit");
  end

endmodule
